weight_stream_loader: RTL and testbench

- Upstream write-side feeder for the double-buffered weight memory.
- Accepts a valid/ready stream of 32-bit bus beats carrying packed signed weights and assembles them into N_DIM_ARRAY-lane rows.
- Issues one row write per assembled row to the FC or CNN external write port; the address MSB selects the ping-pong bank.
- Tracks per-bank "loaded" flags so a bank still in use by compute is never overwritten.

---
 rtl/weight_stream_loader.sv | 215 +++++++++++++++++++++
 tb/tb_weight_stream_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_loader.sv
// weight_stream_loader
// Write-side feeder for the double-buffered weight memory. Packs a stream of
// 32-bit bus beats into N_DIM_ARRAY-lane rows and issues one row write per
// completed row on the FC or CNN external port. The address MSB selects the
// ping-pong bank. Per-bank "loaded" flags stop a start from overwriting a bank
// that compute has not released yet.
//
// Handshake: a beat transfers on every rising edge where in_valid and
// in_ready are both high. in_ready is high only in LOAD. in_data must be held
// stable while in_valid is high and in_ready is low.
//
// Write timing: the row write strobe is registered, so it is high in the
// cycle after the accept of the last beat of a row. done is likewise
// registered and is high in the cycle after the DONE state.
module weight_stream_loader #(
   parameter int N_DIM_ARRAY             = 16,
   parameter int WEIGHT_DATA_WIDTH       = 8,
   parameter int WEIGHT_MEMORY_ADDR_SIZE = 16,
   parameter int BUS_WIDTH               = 32
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic                                               start,
   input  logic [2:0]                                         mode,
   input  logic                                               bank,
   input  logic [WEIGHT_MEMORY_ADDR_SIZE-2:0]                 base_addr,
   input  logic [15:0]                                        num_rows,
   input  logic                                               abort,
   input  logic [1:0]                                         release_bank,
   input  logic [BUS_WIDTH-1:0]                               in_data,
   input  logic                                               in_valid,
   output logic                                               in_ready,
   output logic                                               wr_en_ext_fc_w,
   output logic                                               wr_en_ext_cnn_w,
   output logic [WEIGHT_MEMORY_ADDR_SIZE-1:0]                 wr_addr_ext_w,
   output logic signed [N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0]    wr_data_ext_w,
   output logic                                               busy,
   output logic                                               done,
   output logic                                               start_err,
   output logic [1:0]                                         bank_loaded
);

   localparam int LANES_PER_BEAT = BUS_WIDTH / WEIGHT_DATA_WIDTH;
   localparam int BEATS_PER_ROW  = N_DIM_ARRAY / LANES_PER_BEAT;
   localparam int BEAT_W         = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
   localparam int ROW_AW         = WEIGHT_MEMORY_ADDR_SIZE - 1;

   // Only MODE_FC is decoded; every other mode value writes the CNN port.
   localparam logic [2:0] MODE_FC = 3'd1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef logic [N_DIM_ARRAY-1:0][WEIGHT_DATA_WIDTH-1:0] row_t;

   state_t                       state_q, state_d;
   logic                         mode_fc_q, mode_fc_d;
   logic                         bank_q, bank_d;
   logic [ROW_AW-1:0]            row_addr_q, row_addr_d;
   logic [15:0]                  num_rows_q, num_rows_d;
   logic [15:0]                  row_idx_q, row_idx_d;
   logic [BEAT_W-1:0]            beat_cnt_q, beat_cnt_d;
   logic                         set_on_done_q, set_on_done_d;
   row_t                         row_q, row_d;
   row_t                         wr_data_q, wr_data_d;
   logic                         wr_fc_q, wr_fc_d;
   logic                         wr_cnn_q, wr_cnn_d;
   logic [WEIGHT_MEMORY_ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic                         done_q, done_d;
   logic                         start_err_q, start_err_d;
   logic [1:0]                   loaded_q, loaded_d;
   logic                         accept;
   logic                         last_beat;

   assign accept    = in_valid && (state_q == S_LOAD);
   assign last_beat = (beat_cnt_q == BEAT_W'(BEATS_PER_ROW - 1));

   // Next-state and next-output logic for the load FSM.
   always_comb begin
      state_d       = state_q;
      mode_fc_d     = mode_fc_q;
      bank_d        = bank_q;
      row_addr_d    = row_addr_q;
      num_rows_d    = num_rows_q;
      row_idx_d     = row_idx_q;
      beat_cnt_d    = beat_cnt_q;
      set_on_done_d = set_on_done_q;
      row_d         = row_q;
      wr_data_d     = wr_data_q;
      wr_fc_d       = 1'b0;
      wr_cnn_d      = 1'b0;
      wr_addr_d     = wr_addr_q;
      done_d        = 1'b0;
      start_err_d   = 1'b0;
      // release clears first; a same-cycle DONE set below overrides it
      loaded_d      = loaded_q & ~release_bank;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (loaded_q[bank]) begin
                  start_err_d = 1'b1;
               end else if (num_rows == 16'd0) begin
                  // empty job: completes without writing or marking a bank
                  set_on_done_d = 1'b0;
                  state_d       = S_DONE;
               end else begin
                  mode_fc_d     = (mode == MODE_FC);
                  bank_d        = bank;
                  row_addr_d    = base_addr;
                  num_rows_d    = num_rows;
                  row_idx_d     = 16'd0;
                  beat_cnt_d    = '0;
                  set_on_done_d = 1'b1;
                  state_d       = S_LOAD;
               end
            end
         end

         S_LOAD: begin
            if (accept) begin
               for (int j = 0; j < N_DIM_ARRAY; j++) begin
                  if (BEAT_W'(j / LANES_PER_BEAT) == beat_cnt_q) begin
                     row_d[j] = in_data[(j % LANES_PER_BEAT)*WEIGHT_DATA_WIDTH +: WEIGHT_DATA_WIDTH];
                  end
               end
               if (last_beat) begin
                  beat_cnt_d = '0;
                  wr_data_d  = row_d;
                  wr_fc_d    = mode_fc_q;
                  wr_cnn_d   = !mode_fc_q;
                  wr_addr_d  = {bank_q, row_addr_q};
                  // row address wraps inside the bank; the bank bit is separate
                  row_addr_d = row_addr_q + 1'b1;
                  row_idx_d  = row_idx_q + 16'd1;
                  if (row_idx_q == num_rows_q - 16'd1) begin
                     state_d = S_DONE;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
            // abort drops the partial row but keeps a write scheduled this cycle
            if (abort) begin
               state_d = S_IDLE;
            end
         end

         S_DONE: begin
            done_d = 1'b1;
            if (set_on_done_q) begin
               loaded_d[bank_q] = 1'b1;
            end
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs; everything clears on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         mode_fc_q     <= 1'b0;
         bank_q        <= 1'b0;
         row_addr_q    <= '0;
         num_rows_q    <= 16'd0;
         row_idx_q     <= 16'd0;
         beat_cnt_q    <= '0;
         set_on_done_q <= 1'b0;
         row_q         <= '0;
         wr_data_q     <= '0;
         wr_fc_q       <= 1'b0;
         wr_cnn_q      <= 1'b0;
         wr_addr_q     <= '0;
         done_q        <= 1'b0;
         start_err_q   <= 1'b0;
         loaded_q      <= 2'b00;
      end else begin
         state_q       <= state_d;
         mode_fc_q     <= mode_fc_d;
         bank_q        <= bank_d;
         row_addr_q    <= row_addr_d;
         num_rows_q    <= num_rows_d;
         row_idx_q     <= row_idx_d;
         beat_cnt_q    <= beat_cnt_d;
         set_on_done_q <= set_on_done_d;
         row_q         <= row_d;
         wr_data_q     <= wr_data_d;
         wr_fc_q       <= wr_fc_d;
         wr_cnn_q      <= wr_cnn_d;
         wr_addr_q     <= wr_addr_d;
         done_q        <= done_d;
         start_err_q   <= start_err_d;
         loaded_q      <= loaded_d;
      end
   end

   assign in_ready        = (state_q == S_LOAD);
   assign busy            = (state_q == S_LOAD);
   assign wr_en_ext_fc_w  = wr_fc_q;
   assign wr_en_ext_cnn_w = wr_cnn_q;
   assign wr_addr_ext_w   = wr_addr_q;
   assign wr_data_ext_w   = wr_data_q;
   assign done            = done_q;
   assign start_err       = start_err_q;
   assign bank_loaded     = loaded_q;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader. Inputs are driven 1 ns after the
// rising edge and outputs are checked at the same point; a negedge monitor
// counts write strobes and done pulses and logs write addresses.
module tb_weight_stream_loader;

   localparam logic [2:0] MODE_FC  = 3'd1;
   localparam logic [2:0] MODE_CNN = 3'd2;
   localparam logic [127:0] ROW_A  = 128'h0F0E0D0C0B0A09080706050403020100;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   mode = 3'd0;
   logic         bank = 1'b0;
   logic [14:0]  base_addr = '0;
   logic [15:0]  num_rows = '0;
   logic         abort = 1'b0;
   logic [1:0]   release_bank = 2'b00;
   logic [31:0]  in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         wr_en_ext_fc_w;
   logic         wr_en_ext_cnn_w;
   logic [15:0]  wr_addr_ext_w;
   logic signed [127:0] wr_data_ext_w;
   logic         busy;
   logic         done;
   logic         start_err;
   logic [1:0]   bank_loaded;

   int n_checks = 0;
   int n_fail   = 0;
   int fc_cnt   = 0;
   int cnn_cnt  = 0;
   int done_cnt = 0;
   int stall_cnt = 0;
   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];

   weight_stream_loader dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .mode            (mode),
      .bank            (bank),
      .base_addr       (base_addr),
      .num_rows        (num_rows),
      .abort           (abort),
      .release_bank    (release_bank),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .wr_en_ext_fc_w  (wr_en_ext_fc_w),
      .wr_en_ext_cnn_w (wr_en_ext_cnn_w),
      .wr_addr_ext_w   (wr_addr_ext_w),
      .wr_data_ext_w   (wr_data_ext_w),
      .busy            (busy),
      .done            (done),
      .start_err       (start_err),
      .bank_loaded     (bank_loaded)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // write/done monitor
   always @(negedge clk) begin
      if (reset) begin
         if (wr_en_ext_fc_w) fc_cnt++;
         if (wr_en_ext_cnn_w) cnn_cnt++;
         if (wr_en_ext_fc_w || wr_en_ext_cnn_w) got_q.push_back(wr_addr_ext_w);
         if (done) done_cnt++;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [2:0] m, input logic b, input logic [14:0] base,
                           input logic [15:0] n);
      mode = m; bank = b; base_addr = base; num_rows = n; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Present one beat and wait (bounded) until it is accepted; leaves in_valid high.
   task automatic send_beat(input logic [31:0] d);
      int budget;
      budget = 0;
      in_data = d;
      in_valid = 1'b1;
      while (!in_ready && budget < 20) begin
         stall_cnt++;
         budget++;
         tick();
      end
      check("in_ready_wait", {127'd0, in_ready}, 128'd1);
      tick();
   endtask

   task automatic send_row_a();
      send_beat(32'h03020100);
      send_beat(32'h07060504);
      send_beat(32'h0B0A0908);
      send_beat(32'h0F0E0D0C);
   endtask

   initial begin
      int fc0, cnn0, done0;
      logic [31:0] d;

      // reset state
      tick(); tick();
      check("rst_in_ready", {127'd0, in_ready}, 128'd0);
      check("rst_strobes", {126'd0, wr_en_ext_fc_w, wr_en_ext_cnn_w}, 128'd0);
      check("rst_wr_data", wr_data_ext_w, 128'd0);
      check("rst_bank_loaded", {126'd0, bank_loaded}, 128'd0);
      reset = 1'b1;
      tick();
      check("post_rst_in_ready", {127'd0, in_ready}, 128'd0);

      // single FC row, bank 0, base 5
      do_start(MODE_FC, 1'b0, 15'd5, 16'd1);
      check("t1_busy", {127'd0, busy}, 128'd1);
      send_row_a();
      in_valid = 1'b0;
      check("t1_fc_strobe", {127'd0, wr_en_ext_fc_w}, 128'd1);
      check("t1_cnn_strobe", {127'd0, wr_en_ext_cnn_w}, 128'd0);
      check("t1_addr", {112'd0, wr_addr_ext_w}, 128'h0005);
      check("t1_data", wr_data_ext_w, ROW_A);
      check("t1_in_ready_drop", {127'd0, in_ready}, 128'd0);
      check("t1_done_not_yet", {127'd0, done}, 128'd0);
      tick();
      check("t1_done", {127'd0, done}, 128'd1);
      check("t1_loaded", {126'd0, bank_loaded}, 128'b01);
      check("t1_strobe_single", {127'd0, wr_en_ext_fc_w}, 128'd0);
      check("t1_data_hold", wr_data_ext_w, ROW_A);
      tick();
      check("t1_done_single", {127'd0, done}, 128'd0);
      check("t1_fc_count", fc_cnt, 1);

      // bank guard
      do_start(MODE_FC, 1'b0, 15'd0, 16'd1);
      check("guard_start_err", {127'd0, start_err}, 128'd1);
      check("guard_not_busy", {127'd0, busy}, 128'd0);
      tick();
      check("guard_err_single", {127'd0, start_err}, 128'd0);
      release_bank = 2'b01;
      tick();
      release_bank = 2'b00;
      check("guard_released", {126'd0, bank_loaded}, 128'b00);

      // restart with stalls between beats
      do_start(MODE_FC, 1'b0, 15'd0, 16'd1);
      check("stall_busy", {127'd0, busy}, 128'd1);
      send_beat(32'h03020100); in_valid = 1'b0; tick();
      send_beat(32'h07060504); in_valid = 1'b0; tick();
      send_beat(32'h0B0A0908); in_valid = 1'b0; tick();
      check("stall_no_early_write", fc_cnt, 1);
      send_beat(32'h0F0E0D0C);
      in_valid = 1'b0;
      check("stall_fc_strobe", {127'd0, wr_en_ext_fc_w}, 128'd1);
      check("stall_addr", {112'd0, wr_addr_ext_w}, 128'h0000);
      check("stall_data", wr_data_ext_w, ROW_A);
      tick();
      check("stall_done", {127'd0, done}, 128'd1);
      tick();

      // CNN multi-row into bank 1 with address wrap
      release_bank = 2'b01;
      tick();
      release_bank = 2'b00;
      got_q.delete();
      exp_q.push_back(16'hFFFE);
      exp_q.push_back(16'hFFFF);
      exp_q.push_back(16'h8000);
      do_start(MODE_CNN, 1'b1, 15'h7FFE, 16'd3);
      stall_cnt = 0;
      for (int r = 0; r < 3; r++) begin
         for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(r*16 + b*4 + k);
            send_beat(d);
         end
      end
      in_valid = 1'b0;
      check("cnn_strobe", {127'd0, wr_en_ext_cnn_w}, 128'd1);
      check("cnn_last_data", wr_data_ext_w, 128'h2F2E2D2C2B2A29282726252423222120);
      check("cnn_in_ready_drop", {127'd0, in_ready}, 128'd0);
      tick();
      check("cnn_done", {127'd0, done}, 128'd1);
      check("cnn_loaded", {126'd0, bank_loaded}, 128'b10);
      tick();
      check("cnn_count", cnn_cnt, 3);
      check("cnn_fc_unchanged", fc_cnt, 2);
      check("cnn_no_bubbles", stall_cnt, 0);
      check("cnn_addr_count", got_q.size(), 3);
      while (exp_q.size() > 0 && got_q.size() > 0)
         check("cnn_addr", {112'd0, got_q.pop_front()}, {112'd0, exp_q.pop_front()});

      // release coinciding with DONE on the same bank
      do_start(MODE_FC, 1'b0, 15'h0010, 16'd1);
      send_row_a();
      in_valid = 1'b0;
      release_bank = 2'b01;
      tick();
      release_bank = 2'b00;
      check("coinc_done", {127'd0, done}, 128'd1);
      check("coinc_loaded", {126'd0, bank_loaded}, 128'b11);
      release_bank = 2'b10;
      tick();
      release_bank = 2'b00;
      check("rel_bank1", {126'd0, bank_loaded}, 128'b01);

      // abort after 6 beats of a 2-row job on bank 1
      cnn0 = cnn_cnt; done0 = done_cnt;
      do_start(MODE_CNN, 1'b1, 15'd0, 16'd2);
      for (int i = 0; i < 6; i++) send_beat(32'h11111111 * i);
      in_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_in_ready", {127'd0, in_ready}, 128'd0);
      check("abort_busy", {127'd0, busy}, 128'd0);
      tick(); tick();
      check("abort_writes", cnn_cnt - cnn0, 1);
      check("abort_no_done", done_cnt - done0, 0);
      check("abort_loaded", {126'd0, bank_loaded}, 128'b01);

      // zero-row job: done two cycles after start, no writes, no flag change
      fc0 = fc_cnt; cnn0 = cnn_cnt;
      do_start(MODE_CNN, 1'b1, 15'd0, 16'd0);
      check("zero_done_early", {127'd0, done}, 128'd0);
      check("zero_no_busy", {127'd0, busy}, 128'd0);
      tick();
      check("zero_done", {127'd0, done}, 128'd1);
      tick();
      check("zero_loaded", {126'd0, bank_loaded}, 128'b01);
      check("zero_writes", (fc_cnt - fc0) + (cnn_cnt - cnn0), 0);

      // reset mid-row
      do_start(MODE_FC, 1'b1, 15'd0, 16'd1);
      send_beat(32'hAABBCCDD);
      send_beat(32'h01020304);
      in_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("midrst_in_ready", {127'd0, in_ready}, 128'd0);
      check("midrst_busy", {127'd0, busy}, 128'd0);
      check("midrst_loaded", {126'd0, bank_loaded}, 128'd0);
      check("midrst_wr_data", wr_data_ext_w, 128'd0);
      check("midrst_addr", {112'd0, wr_addr_ext_w}, 128'd0);
      tick();
      reset = 1'b1;
      tick();
      check("post_midrst_idle", {127'd0, in_ready}, 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
